// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential signed radix-4 Booth multiplier, one recoded digit per clock
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Z
);

    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH+1:0] mcand;
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic             bm1;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0] pp;
    logic [WIDTH+1:0] mcand2;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] acc_sh;
    logic [WIDTH-1:0] mplier_sh;
    logic             bm1_sh;
    logic             accept;
    logic             last_step;

    // Booth digit selection from {b[2i+1], b[2i], b[2i-1]}; 2A fits because mcand is WIDTH+2 wide.
    always_comb begin
        mcand2 = {mcand[WIDTH:0], 1'b0};
        pp     = '0;
        case ({mplier[1:0], bm1})
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand2;
            3'b100:         pp = -mcand2;
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        sum       = acc + pp;
        acc_sh    = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        mplier_sh = {sum[1:0], mplier[WIDTH-1:2]};
        bm1_sh    = mplier[1];
    end

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (count == LAST);

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            bm1    <= 1'b0;
            count  <= '0;
            Z      <= '0;
        end else if (accept) begin
            mcand  <= {{2{A[WIDTH-1]}}, A};
            acc    <= '0;
            mplier <= B;
            bm1    <= 1'b0;
            count  <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sh;
            mplier <= mplier_sh;
            bm1    <= bm1_sh;
            count  <= count + ONE;
            // The two headroom bits are pure sign extension by now and are dropped.
            if (last_step) Z <= {acc_sh[WIDTH-1:0], mplier_sh};
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - scoreboard bench for booth_seq_multiplier
module tb_booth_seq_multiplier;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] Z;

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] z;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   total;
    int   passed;
    int   run_len;

    initial begin
        cyc = 0;
        total = 0;
        passed = 0;
        run_len = 0;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
        else passed++;
    endtask

    // Monitor: pops the scoreboard on every done, and measures busy run lengths.
    always @(negedge clock) begin
        if (!clear) begin
            run_len = 0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (run_len != 0) begin
                check("busy_len", 64'(run_len), 64'd16);
                run_len = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_Z"}, Z, e.z);
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    // Called at a negedge; the following posedge accepts, done shows 16 edges after that.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] req);
        exp_t e;
        wait_idle();
        A = a;
        B = b;
        start = 1'b1;
        e.z = req;
        e.cyc = cyc + 17;
        e.name = name;
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        clear = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_Z", Z, 64'd0);
        clear = 1'b1;
        @(negedge clock);

        issue("six_x_m7", 32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6);
        issue("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue("min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        issue("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        issue("zero_x", 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000);
        issue("max_x_2", 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE);

        // Re-pulsed start during RUN must be ignored.
        issue("ignore_restart", 32'd5, 32'd9, 64'h0000_0000_0000_002D);
        repeat (2) @(negedge clock);
        A = 32'd1000;
        B = 32'd1000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        A = 32'hFFFF_0000;
        B = 32'd77;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        // start held through DONE: second op accepted straight from DONE.
        wait_idle();
        begin
            exp_t e;
            int n;
            A = 32'hFFFF_FFFD;
            B = 32'd100;
            start = 1'b1;
            e.z = 64'hFFFF_FFFF_FFFF_FED4;
            e.cyc = cyc + 17;
            e.name = "held_first";
            exp_q.push_back(e);
            @(negedge clock);
            n = 0;
            while (!done && n < 40) begin
                @(negedge clock);
                n++;
            end
            if (n >= 40) check("held_done_timeout", 64'd1, 64'd0);
            A = 32'd7;
            B = 32'hFFFF_FFF8;
            e.z = 64'hFFFF_FFFF_FFFF_FFC8;
            e.cyc = cyc + 17;
            e.name = "held_second";
            exp_q.push_back(e);
            @(negedge clock);
            start = 1'b0;
        end

        // clear mid-run abandons the operation; done must not pulse for it.
        wait_idle();
        @(negedge clock);
        A = 32'd123;
        B = 32'd456;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_Z", Z, 64'd0);
        clear = 1'b1;
        @(negedge clock);
        issue("after_clear", 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340);

        for (int i = 0; i < 200; i++) begin
            logic signed [63:0] sa;
            logic signed [63:0] sb;
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            sa = $signed(ra);
            sb = $signed(rb);
            issue("random", ra, rb, 64'(sa * sb));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        begin
            int n;
            n = 0;
            while ((exp_q.size() != 0 || busy || done) && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (n >= 100) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        end
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
